// File: rtl/hebbian_pkg.sv
// Shared types and helpers for the Hebbian weight bank: FSM encoding,
// bipolar state decode and the symmetric saturation limits.
package hebbian_pkg;

    localparam int DEFAULT_W_WIDTH = 10;

    // Symmetric limits: the most negative two's-complement code is never stored.
    localparam int W_MAX = (1 << (DEFAULT_W_WIDTH - 1)) - 1;
    localparam int W_MIN = -W_MAX;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int w_max_of(input int width);
        return (1 << (width - 1)) - 1;
    endfunction

    // 2'b10 is not a legal bipolar code and decodes to 0.
    function automatic logic signed [1:0] bipolar_decode(input logic [1:0] code);
        case (code)
            2'b01:   return 2'sb01;
            2'b11:   return 2'sb11;
            default: return 2'sb00;
        endcase
    endfunction

endpackage

// File: rtl/hebbian_sat_update.sv
// Single-weight Hebbian update with symmetric saturation. The optional decay
// term is compiled in only when WEIGHT_DECAY_EN is defined.
module hebbian_sat_update
    import hebbian_pkg::*;
#(
    parameter int W_WIDTH     = DEFAULT_W_WIDTH,
    parameter int LR_WIDTH    = 4,
    parameter int DECAY_SHIFT = 4,
    parameter int SAT_MAX     = W_MAX,
    parameter int SAT_MIN     = W_MIN
) (
    input  logic signed [W_WIDTH-1:0]  w,
    input  logic signed [1:0]          xin_d,
    input  logic signed [1:0]          x_d,
    input  logic signed [LR_WIDTH-1:0] lr,
    output logic signed [W_WIDTH-1:0]  w_next,
    output logic                       sat
);

    localparam int SW = W_WIDTH + 1;

    if (LR_WIDTH >= W_WIDTH) begin : g_bad_lr
        $error("hebbian_sat_update: LR_WIDTH must be narrower than W_WIDTH");
    end
    if (DECAY_SHIFT < 1 || DECAY_SHIFT >= W_WIDTH) begin : g_bad_shift
        $error("hebbian_sat_update: DECAY_SHIFT out of range");
    end

    logic signed [SW-1:0] w_ext;
    logic signed [SW-1:0] lr_ext;
    logic signed [SW-1:0] hi;
    logic signed [SW-1:0] lo;
    logic signed [SW-1:0] p;
    logic signed [SW-1:0] s;

    assign w_ext  = {w[W_WIDTH-1], w};
    assign lr_ext = {{(SW - LR_WIDTH){lr[LR_WIDTH-1]}}, lr};
    assign hi     = SW'(SAT_MAX);
    assign lo     = SW'(SAT_MIN);

`ifdef WEIGHT_DECAY_EN
    logic signed [SW-1:0] decay;
    assign decay = w_ext >>> DECAY_SHIFT;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        p      = '0;
        s      = w_ext;
        w_next = w;
        sat    = 1'b0;

        // Both operands are in {-1,0,+1}: equal signs give +LR, opposite give -LR.
        if (xin_d != 2'sd0 && x_d != 2'sd0) begin
            p = (xin_d == x_d) ? lr_ext : -lr_ext;
        end

        if (p != '0) begin
`ifdef WEIGHT_DECAY_EN
            s = w_ext - decay + p;
`else
            s = w_ext + p;
`endif
        end

        if (s > hi) begin
            w_next = hi[W_WIDTH-1:0];
            sat    = 1'b1;
        end else if (s < lo) begin
            w_next = lo[W_WIDTH-1:0];
            sat    = 1'b1;
        end else begin
            w_next = s[W_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hebbian_weight_bank.sv
// Hebbian weight bank: one signed weight per presynaptic neuron, updated serially
// through a shared datapath per learning pass. Optional decay: WEIGHT_DECAY_EN.
module hebbian_weight_bank
    import hebbian_pkg::*;
#(
    parameter int N_NEURONS   = 20,
    parameter int W_WIDTH     = DEFAULT_W_WIDTH,
    parameter int LR          = 7,
    parameter int LR_WIDTH    = 4,
    parameter int DECAY_SHIFT = 4
) (
    input  logic                           learn_clock,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           clear,
    input  logic [1:0]                     xin,
    input  logic [2*N_NEURONS-1:0]         xalt,
    output logic                           busy,
    output logic                           done,
    output logic                           sat_flag,
    output logic [N_NEURONS*W_WIDTH-1:0]   weights_packed
);

    localparam int               IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam int               SAT_LIM  = w_max_of(W_WIDTH);

    state_t state;
    state_t next_state;
    logic   load;

    logic [IDX_W-1:0]          idx;
    logic [1:0]                xin_q;
    logic [1:0]                x_q      [N_NEURONS];
    logic signed [W_WIDTH-1:0] weight_q [N_NEURONS];

    logic signed [1:0]         xin_d;
    logic signed [1:0]         x_d;
    logic signed [W_WIDTH-1:0] w_cur;
    logic signed [W_WIDTH-1:0] w_next;
    logic                      sat;

    always_ff @(posedge learn_clock) begin
        // NOTE: sequential state is assigned with <= only, so every flop sees pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_UPDATE;
                    load       = 1'b1;
                end
            end
            ST_UPDATE: begin
                if (idx == LAST_IDX) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
                if (start) begin
                    next_state = ST_UPDATE;
                    load       = 1'b1;
                end
            end
            default: next_state = ST_IDLE;
        endcase
        // clear aborts any pass and suppresses the done pulse.
        if (clear) begin
            next_state = ST_IDLE;
            load       = 1'b0;
        end
    end

    // Snapshot registers are always written by load before they are read, so they carry no reset.
    always_ff @(posedge learn_clock) begin
        if (load) begin
            xin_q <= xin;
            for (int j = 0; j < N_NEURONS; j++) begin
                x_q[j] <= xalt[2*j +: 2];
            end
        end
    end

    always_ff @(posedge learn_clock) begin
        // NOTE: the weight array is a flop bank, not a RAM, so it can and must take reset and clear.
        if (rst || clear) begin
            idx      <= '0;
            sat_flag <= 1'b0;
            for (int j = 0; j < N_NEURONS; j++) begin
                weight_q[j] <= '0;
            end
        end else if (load) begin
            idx <= '0;
        end else if (state == ST_UPDATE) begin
            weight_q[idx] <= w_next;
            if (sat) begin
                sat_flag <= 1'b1;
            end
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    assign xin_d = bipolar_decode(xin_q);
    assign x_d   = bipolar_decode(x_q[idx]);
    assign w_cur = weight_q[idx];

    hebbian_sat_update #(
        .W_WIDTH     (W_WIDTH),
        .LR_WIDTH    (LR_WIDTH),
        .DECAY_SHIFT (DECAY_SHIFT),
        .SAT_MAX     (SAT_LIM),
        .SAT_MIN     (-SAT_LIM)
    ) u_update (
        .w      (w_cur),
        .xin_d  (xin_d),
        .x_d    (x_d),
        .lr     (LR_WIDTH'(LR)),
        .w_next (w_next),
        .sat    (sat)
    );

    assign busy = (state == ST_UPDATE);
    assign done = (state == ST_DONE);

    for (genvar j = 0; j < N_NEURONS; j++) begin : g_pack
        assign weights_packed[j*W_WIDTH +: W_WIDTH] = weight_q[j];
    end

endmodule
